// File: rtl/regfile32.sv
// rtl/regfile32.sv - 32-entry register file, two combinational read ports, one write port, bulk clear
// Storage feeds the mux32 stage: the entries drive d0..d31 and the read addresses drive s.
module regfile32 #(
  parameter int WIDTH    = 5,
  parameter bit ZERO_REG = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_ena,
  input  logic [4:0]       wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [4:0]       rd_addr0,
  output logic [WIDTH-1:0] rd_data0,
  input  logic [4:0]       rd_addr1,
  output logic [WIDTH-1:0] rd_data1,
  input  logic             clr_req,
  output logic             clr_busy,
  output logic             clr_done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic [4:0]       ptr_q;
  logic [WIDTH-1:0] mem [32];
  logic             wr_ok;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (clr_req) state_d = CLEAR;
      CLEAR:   if (ptr_q == 5'd31) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // A clear request wins over a write presented on the same edge.
  assign wr_ok = (state_q == IDLE) && !clr_req && wr_ena &&
                 !(ZERO_REG && (wr_addr == 5'd0));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      for (int i = 0; i < 32; i++) mem[i] <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == CLEAR) begin
        mem[ptr_q] <= '0;
        ptr_q      <= ptr_q + 5'd1;
      end else if ((state_q == IDLE) && clr_req) begin
        ptr_q <= '0;
      end
      if (wr_ok) mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data0 = (ZERO_REG && (rd_addr0 == 5'd0)) ? '0 : mem[rd_addr0];
  assign rd_data1 = (ZERO_REG && (rd_addr1 == 5'd0)) ? '0 : mem[rd_addr1];

  assign clr_busy = (state_q == CLEAR);
  assign clr_done = (state_q == DONE);

endmodule

// File: tb/tb_regfile32.sv
// tb/tb_regfile32.sv - self-checking bench for regfile32 (ZERO_REG=1 and ZERO_REG=0 instances)
module tb_regfile32;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       wr_ena = 1'b0;
  logic [4:0] wr_addr = '0;
  logic [4:0] wr_data = '0;
  logic [4:0] rd_addr0 = '0;
  logic [4:0] rd_addr1 = '0;
  logic       clr_req = 1'b0;

  logic [4:0] z_rd0, z_rd1, n_rd0, n_rd1;
  logic       z_busy, z_done, n_busy, n_done;

  int vectors = 0;
  int miscompares = 0;
  bit started = 1'b0;

  // Reference state: plain arrays plus a clear-progress counter
  // (-1 idle, 0..31 entries already cleared, 32 completion cycle).
  logic [4:0] mz [32];
  logic [4:0] mn [32];
  int         phase = -1;

  regfile32 #(.WIDTH(5), .ZERO_REG(1'b1)) dut_z (
    .clk(clk), .rst(rst), .wr_ena(wr_ena), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr0(rd_addr0), .rd_data0(z_rd0), .rd_addr1(rd_addr1), .rd_data1(z_rd1),
    .clr_req(clr_req), .clr_busy(z_busy), .clr_done(z_done)
  );

  regfile32 #(.WIDTH(5), .ZERO_REG(1'b0)) dut_n (
    .clk(clk), .rst(rst), .wr_ena(wr_ena), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr0(rd_addr0), .rd_data0(n_rd0), .rd_addr1(rd_addr1), .rd_data1(n_rd1),
    .clr_req(clr_req), .clr_busy(n_busy), .clr_done(n_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  initial begin
    for (int i = 0; i < 32; i++) begin
      mz[i] = '0;
      mn[i] = '0;
    end
  end

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) begin
        mz[i] = '0;
        mn[i] = '0;
      end
      phase = -1;
    end else if (phase == -1) begin
      if (clr_req) phase = 0;
      else if (wr_ena) begin
        mn[wr_addr] = wr_data;
        if (wr_addr != 5'd0) mz[wr_addr] = wr_data;
      end
    end else if (phase < 32) begin
      mz[phase] = '0;
      mn[phase] = '0;
      phase++;
    end else begin
      phase = -1;
    end
  end

  always @(negedge clk) begin
    if (started) begin
      check("z_rd0", z_rd0, (rd_addr0 == 5'd0) ? 5'd0 : mz[rd_addr0]);
      check("z_rd1", z_rd1, (rd_addr1 == 5'd0) ? 5'd0 : mz[rd_addr1]);
      check("n_rd0", n_rd0, mn[rd_addr0]);
      check("n_rd1", n_rd1, mn[rd_addr1]);
      check("z_busy", z_busy, (phase >= 0 && phase < 32));
      check("z_done", z_done, (phase == 32));
      check("n_busy", n_busy, (phase >= 0 && phase < 32));
      check("n_done", n_done, (phase == 32));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic write(input logic [4:0] a, input logic [4:0] d);
    wr_ena = 1'b1; wr_addr = a; wr_data = d;
    step();
    wr_ena = 1'b0;
  endtask

  int busy_cnt, done_cnt, busy_after_done;

  initial begin
    // 1) reset held: every address reads 0, status low
    #2;
    for (int a = 0; a < 32; a++) begin
      rd_addr0 = a[4:0]; rd_addr1 = 5'(31 - a);
      #1;
      check("rst_rd0", z_rd0, 0);
      check("rst_rd1", n_rd1, 0);
    end
    check("rst_busy", z_busy, 0);
    check("rst_done", z_done, 0);
    step();
    started = 1'b1;
    step();
    rst = 1'b0;
    step();

    // 2) mem[i] = (i+1) mod 32 for i = 1..31
    for (int i = 1; i < 32; i++) write(i[4:0], 5'(i + 1));
    for (int i = 0; i < 32; i++) begin
      rd_addr0 = i[4:0]; rd_addr1 = i[4:0];
      #1;
      check("sweep_rd0", z_rd0, (i == 0 || i == 31) ? 0 : i + 1);
      check("sweep_rd1", z_rd1, (i == 0 || i == 31) ? 0 : i + 1);
    end

    // 3) entry 0 behaviour per instance
    write(5'd0, 5'b10101);
    rd_addr0 = 5'd0;
    #1;
    check("zero_reg1", z_rd0, 5'b00000);
    check("zero_reg0", n_rd0, 5'b10101);
    step();

    // 4) read-after-write, no bypass
    rd_addr0 = 5'd7;
    wr_ena = 1'b1; wr_addr = 5'd7; wr_data = 5'b11001;
    #1;
    check("raw_before", z_rd0, 5'd8);
    step();
    wr_ena = 1'b0;
    check("raw_after", z_rd0, 5'b11001);

    // 5) bulk clear with a dropped write in the middle
    for (int i = 0; i < 32; i++) write(i[4:0], 5'b11111);
    clr_req = 1'b1;
    step();
    clr_req = 1'b0;
    busy_cnt = 0; done_cnt = 0; busy_after_done = 0;
    for (int c = 0; c < 40; c++) begin
      if (z_busy) busy_cnt++;
      if (z_busy && done_cnt != 0) busy_after_done++;
      if (z_done) done_cnt++;
      if (c == 5) begin
        wr_ena = 1'b1; wr_addr = 5'd3; wr_data = 5'b00111;
      end else wr_ena = 1'b0;
      if (c == 10) begin
        rd_addr0 = 5'd9; rd_addr1 = 5'd10;
        #1;
        check("partial_cleared", n_rd0, 5'd0);
        check("partial_live", n_rd1, 5'b11111);
      end
      step();
    end
    wr_ena = 1'b0;
    check("busy_cycles", busy_cnt, 32);
    check("done_cycles", done_cnt, 1);
    check("busy_after_done", busy_after_done, 0);
    rd_addr0 = 5'd3;
    #1;
    check("dropped_write", z_rd0, 5'd0);
    for (int i = 0; i < 32; i++) begin
      rd_addr1 = i[4:0];
      #1;
      check("cleared", n_rd1, 0);
    end
    step();

    // 6) reset ten cycles into a clear
    for (int i = 0; i < 32; i++) write(i[4:0], 5'b10110);
    clr_req = 1'b1;
    step();
    clr_req = 1'b0;
    repeat (10) step();
    #2;
    rst = 1'b1;
    #1;
    check("midrst_busy", z_busy, 0);
    check("midrst_done", z_done, 0);
    for (int i = 0; i < 32; i++) begin
      rd_addr0 = i[4:0];
      #0.1;
      check("midrst_entry", n_rd0, 0);
    end
    step();
    rst = 1'b0;
    done_cnt = 0;
    for (int c = 0; c < 36; c++) begin
      if (z_done || z_busy) done_cnt++;
      step();
    end
    check("no_done_pulse", done_cnt, 0);
    write(5'd12, 5'b01101);
    rd_addr0 = 5'd12;
    #1;
    check("post_rst_write", z_rd0, 5'b01101);
    step();
    step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
